// File: rtl/im_loader_pkg.sv
// Shared constants and state encoding for the program-image loader.
package im_loader_pkg;

  // Frame start marker that opens every program image.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Loader states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    ERR   = 3'd4
  } ld_state_t;

endpackage

// File: rtl/im_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words from a
// framed byte stream and writes them into the instruction memory, holding
// the CPU while a load is in progress or after a failed one.
module im_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = im_loader_pkg::SYNC_BYTE,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter int unsigned TO_W      = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_wr_addr,
  output logic [31:0]       im_wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  import im_loader_pkg::*;

  // Largest word count that fits the IM; frames asking for more are rejected.
  localparam int unsigned DEPTH = (ADDR_W < 8) ? (32'd1 << ADDR_W) : 32'd256;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  ld_state_t         state, state_nx;
  logic [7:0]        n_words, n_words_nx;
  logic [7:0]        word_idx, word_idx_nx;
  logic [1:0]        byte_idx, byte_idx_nx;
  logic [31:0]       word_sr, word_sr_nx;
  logic [7:0]        chk, chk_nx;
  logic [TO_W-1:0]   to_cnt, to_cnt_nx;
  logic              wr_en_nx;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [31:0]       wr_data_nx;
  logic              hold_nx;
  logic              done_nx;
  logic              err_nx;
  logic              is_sync;
  logic              too_big;
  logic [31:0]       word_full;

  assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);
  assign too_big   = (32'(rx_data) > DEPTH);
  assign word_full = {rx_data, word_sr[31:8]};

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      n_words    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_sr    <= '0;
      chk        <= '0;
      to_cnt     <= '0;
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      n_words    <= n_words_nx;
      word_idx   <= word_idx_nx;
      byte_idx   <= byte_idx_nx;
      word_sr    <= word_sr_nx;
      chk        <= chk_nx;
      to_cnt     <= to_cnt_nx;
      im_wr_en   <= wr_en_nx;
      im_wr_addr <= wr_addr_nx;
      im_wr_data <= wr_data_nx;
      cpu_hold   <= hold_nx;
      load_done  <= done_nx;
      load_err   <= err_nx;
    end
  end

  // Next-state and next-output logic; strobes default low, the rest hold.
  always_comb begin
    state_nx    = state;
    n_words_nx  = n_words;
    word_idx_nx = word_idx;
    byte_idx_nx = byte_idx;
    word_sr_nx  = word_sr;
    chk_nx      = chk;
    to_cnt_nx   = to_cnt;
    wr_en_nx    = 1'b0;
    wr_addr_nx  = im_wr_addr;
    wr_data_nx  = im_wr_data;
    hold_nx     = cpu_hold;
    done_nx     = 1'b0;
    err_nx      = load_err;

    case (state)
      IDLE, ERR: begin
        if (is_sync) begin
          state_nx  = COUNT;
          hold_nx   = 1'b1;
          err_nx    = 1'b0;
          chk_nx    = '0;
          to_cnt_nx = '0;
        end
      end
      COUNT: begin
        if (rx_valid) begin
          if ((rx_data == 8'd0) || too_big) begin
            state_nx = ERR;
            err_nx   = 1'b1;
          end else begin
            n_words_nx  = rx_data;
            word_idx_nx = '0;
            byte_idx_nx = '0;
            state_nx    = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          word_sr_nx  = word_full;
          chk_nx      = chk ^ rx_data;
          byte_idx_nx = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            wr_en_nx    = 1'b1;
            wr_addr_nx  = ADDR_W'(word_idx);
            wr_data_nx  = word_full;
            word_idx_nx = word_idx + 8'd1;
            if (word_idx == n_words - 8'd1) begin
              state_nx = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == chk) begin
            done_nx  = 1'b1;
            hold_nx  = 1'b0;
            state_nx = IDLE;
          end else begin
            err_nx   = 1'b1;
            state_nx = ERR;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // Inter-byte timeout inside a frame; an arriving byte always wins.
    if ((state == COUNT) || (state == DATA) || (state == CHECK)) begin
      if (rx_valid) begin
        to_cnt_nx = '0;
      end else if (to_cnt == TO_LAST) begin
        to_cnt_nx = '0;
        state_nx  = ERR;
        err_nx    = 1'b1;
      end else begin
        to_cnt_nx = to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected IM writes are queued as payload
// bytes are driven and popped by a monitor when the DUT strobes im_wr_en.
module tb_im_loader;

  localparam int unsigned TO = 20;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        im_wr_en;
  logic [7:0]  im_wr_addr;
  logic [31:0] im_wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  im_loader #(
    .ADDR_W   (8),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (TO),
    .TO_W     (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .im_wr_en  (im_wr_en),
    .im_wr_addr(im_wr_addr),
    .im_wr_data(im_wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned wr_seen = 0;
  int unsigned done_seen = 0;
  logic [39:0] sb[$];
  logic [7:0]  tb_chk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pop and compare every IM write; count done pulses.
  always @(negedge clk) begin
    logic [39:0] e;
    if (im_wr_en === 1'b1) begin
      wr_seen++;
      check("wr_pending", 64'(sb.size() > 0), 64'd1);
      check("wr_excl", 64'(load_done), 64'd0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_addr", 64'(im_wr_addr), 64'(e[39:32]));
        check("wr_data", 64'(im_wr_data), 64'(e[31:0]));
      end
    end
    if (load_done === 1'b1) done_seen++;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [31:0] data);
    logic [7:0] b;
    sb.push_back({addr, data});
    for (int unsigned i = 0; i < 4; i++) begin
      b = data[8*i +: 8];
      tb_chk ^= b;
      send_byte(b);
    end
  endtask

  task automatic start_frame(input logic [7:0] n);
    tb_chk = 8'h00;
    send_byte(8'hA5);
    check("hold_after_sync", 64'(cpu_hold), 64'd1);
    check("err_after_sync", 64'(load_err), 64'd0);
    send_byte(n);
  endtask

  task automatic expect_done(input string tag, input int unsigned done_before);
    check({tag, "_done"}, 64'(load_done), 64'd1);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_err"}, 64'(load_err), 64'd0);
    idle(1);
    check({tag, "_done_1cyc"}, 64'(done_seen), 64'(done_before + 1));
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(im_wr_en), 64'd0);
    check({tag, "_addr"}, 64'(im_wr_addr), 64'd0);
    check({tag, "_data"}, 64'(im_wr_data), 64'd0);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_done"}, 64'(load_done), 64'd0);
    check({tag, "_err"}, 64'(load_err), 64'd0);
  endtask

  initial begin
    int unsigned d0;
    int unsigned w0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tb_chk   = 8'h00;
    idle(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    idle(2);

    // Single-word frame.
    d0 = done_seen;
    start_frame(8'd1);
    send_word(8'd0, 32'h8B000013);
    check("f1_chk_model", 64'(tb_chk), 64'h98);
    send_byte(tb_chk);
    expect_done("f1", d0);

    // Two-word frame.
    d0 = done_seen;
    start_frame(8'd2);
    send_word(8'd0, 32'h04030201);
    send_word(8'd1, 32'h08070605);
    send_byte(tb_chk);
    expect_done("f2", d0);

    // Same frame with a bad checksum: writes happen, then error.
    d0 = done_seen;
    start_frame(8'd2);
    send_word(8'd0, 32'h04030201);
    send_word(8'd1, 32'h08070605);
    send_byte(8'hFF);
    check("badchk_err", 64'(load_err), 64'd1);
    check("badchk_hold", 64'(cpu_hold), 64'd1);
    idle(2);
    check("badchk_no_done", 64'(done_seen), 64'(d0));
    check("badchk_sb", 64'(sb.size()), 64'd0);

    // A valid frame out of ERR recovers.
    d0 = done_seen;
    start_frame(8'd1);
    send_word(8'd0, 32'h8B000013);
    send_byte(tb_chk);
    expect_done("recover", d0);

    // Zero word count.
    w0 = wr_seen;
    start_frame(8'd0);
    check("n0_err", 64'(load_err), 64'd1);
    check("n0_hold", 64'(cpu_hold), 64'd1);
    idle(3);
    check("n0_no_wr", 64'(wr_seen), 64'(w0));

    // Timeout: TO idle cycles after a payload byte.
    w0 = wr_seen;
    start_frame(8'd1);
    send_byte(8'hAA);
    idle(TO - 1);
    check("to_not_yet", 64'(load_err), 64'd0);
    idle(1);
    check("to_err", 64'(load_err), 64'd1);
    check("to_hold", 64'(cpu_hold), 64'd1);
    check("to_no_wr", 64'(wr_seen), 64'(w0));

    // Byte arriving on the TO-th cycle wins.
    d0 = done_seen;
    start_frame(8'd1);
    sb.push_back({8'd0, 32'hDDCCBBAA});
    tb_chk = 8'hAA;
    send_byte(8'hAA);
    idle(TO - 1);
    tb_chk ^= 8'hBB;
    send_byte(8'hBB);
    check("to_edge_no_err", 64'(load_err), 64'd0);
    tb_chk ^= 8'hCC;
    send_byte(8'hCC);
    tb_chk ^= 8'hDD;
    send_byte(8'hDD);
    send_byte(tb_chk);
    expect_done("to_edge", d0);

    // Reset mid-frame after two payload bytes.
    w0 = wr_seen;
    start_frame(8'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    send_byte(8'h11);
    send_byte(8'h22);
    idle(2);
    check("garbage_hold", 64'(cpu_hold), 64'd0);
    check("garbage_no_wr", 64'(wr_seen), 64'(w0));
    d0 = done_seen;
    start_frame(8'd2);
    send_word(8'd0, 32'h12345678);
    send_word(8'd1, 32'h9ABCDEF0);
    send_byte(tb_chk);
    expect_done("fresh", d0);

    idle(3);
    check("final_sb", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
